// File: rtl/distribute_pkg.sv
`default_nettype none
// ============================================================================
// Module      : distribute_pkg
// Description : Constants shared by the distribution-tree switches. Each
//               constant is a one-bit fill value; switches replicate it to
//               their own data or mask width, so one package serves every
//               parameterisation.
// Revision    : 1.0 - initial release
// ============================================================================
package distribute_pkg;

    // Fill bit for payload slices of outputs that are not valid (dummy data).
    localparam logic DUMMY_DATA = 1'b0;

    // Destination mask fill bits: no destination / every destination.
    localparam logic CMD_NONE   = 1'b0;
    localparam logic CMD_BCAST  = 1'b1;

endpackage : distribute_pkg
`default_nettype wire

// File: rtl/distribute_switch_fork.sv
`default_nettype none
// ============================================================================
// Module      : distribute_switch_fork
// Description : Registered 1-to-NUM_OUT distribute switch. One input beat is
//               held until every output addressed by its destination mask has
//               handshaked; outputs drain independently, so a slow consumer
//               stalls only the input. Beats with an empty mask are consumed
//               and counted in a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module distribute_switch_fork
    import distribute_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DATA_WIDTH-1:0]         i_data_bus,
    input  logic [NUM_OUT-1:0]            i_cmd,
    output logic [NUM_OUT-1:0]            o_valid,
    input  logic [NUM_OUT-1:0]            i_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] o_data_bus,
    output logic [CNT_WIDTH-1:0]          o_drop_cnt
);

    localparam logic [NUM_OUT-1:0]    C_MASK_NONE  = {NUM_OUT{CMD_NONE}};
    localparam logic [DATA_WIDTH-1:0] C_DUMMY      = {DATA_WIDTH{DUMMY_DATA}};
    localparam logic [CNT_WIDTH-1:0]  C_CNT_MAX    = {CNT_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_OUT-1:0]    pend_q, pend_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;

    logic [NUM_OUT-1:0]    w_pend_left;
    logic                  w_drain_done;
    logic                  w_accept;

    // Acceptance: the holding stage is free once every pending output
    // handshakes this cycle, which allows drain and refill in the same cycle.
    always_comb begin
        w_pend_left  = pend_q & ~i_ready;
        w_drain_done = (w_pend_left == C_MASK_NONE);
        o_ready      = i_en && w_drain_done;
        w_accept     = i_valid && o_ready;
    end

    // Next state: a new mask overwrites the pending set; otherwise pending
    // bits clear as their outputs handshake. Empty masks bump the counter.
    always_comb begin
        pend_d = w_pend_left;
        data_d = data_q;
        drop_d = drop_q;
        if (w_accept) begin
            pend_d = i_cmd;
            data_d = i_data_bus;
            if ((i_cmd == C_MASK_NONE) && (drop_q != C_CNT_MAX)) begin
                drop_d = drop_q + CNT_WIDTH'(1);
            end
        end
    end

    // State register; reset discards any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            pend_q <= '0;
            drop_q <= '0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    assign o_valid    = pend_q;
    assign o_drop_cnt = drop_q;

    // Per-output data gating: idle outputs present dummy data, not stale beats.
    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
            assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = pend_q[k] ? data_q : C_DUMMY;
        end
    endgenerate

endmodule : distribute_switch_fork
`default_nettype wire

// File: tb/tb_distribute_switch_fork.sv
`default_nettype none
// ============================================================================
// Module      : tb_distribute_switch_fork
// Description : Directed self-checking bench for distribute_switch_fork.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distribute_switch_fork;

    localparam int DW = 32;
    localparam int NO = 4;
    localparam int CW = 4;

    logic               clk;
    logic               rst_n;
    logic               i_en;
    logic               i_valid;
    logic               o_ready;
    logic [DW-1:0]      i_data_bus;
    logic [NO-1:0]      i_cmd;
    logic [NO-1:0]      o_valid;
    logic [NO-1:0]      i_ready;
    logic [NO*DW-1:0]   o_data_bus;
    logic [CW-1:0]      o_drop_cnt;

    int checks;
    int failures;

    distribute_switch_fork #(
        .DATA_WIDTH (DW),
        .NUM_OUT    (NO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_bus (i_data_bus),
        .i_cmd      (i_cmd),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data_bus (o_data_bus),
        .o_drop_cnt (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        i_en       = 1'b1;
        i_valid    = 1'b1;
        i_cmd      = 4'b1111;
        i_data_bus = 32'hDEAD_BEEF;
        i_ready    = 4'b1111;
        tick();
        tick();
        checks++;
        if (o_valid !== 4'b0000) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=%b", o_valid, 4'b0000);
        end
        checks++;
        if (o_data_bus !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", o_data_bus);
        end
        checks++;
        if (o_drop_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_drop got=%0d exp=0", o_drop_cnt);
        end
        i_valid = 1'b0;
        rst_n   = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", o_ready);
        end
        tick();
    endtask

    task automatic test_broadcast();
        logic [DW-1:0] exp_d;
        i_en    = 1'b1;
        i_ready = 4'b1111;
        i_cmd   = 4'b1111;
        i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_d      = 32'hA0 + 32'(i);
            i_data_bus = exp_d;
            #1;
            checks++;
            if (o_ready !== 1'b1) begin
                failures++;
                $display("FAIL bcast_ready beat=%0d got=%b exp=1", i, o_ready);
            end
            tick();
            checks++;
            if (o_valid !== 4'b1111) begin
                failures++;
                $display("FAIL bcast_valid beat=%0d got=%b exp=1111", i, o_valid);
            end
            for (int k = 0; k < NO; k++) begin
                checks++;
                if (o_data_bus[k*DW +: DW] !== exp_d) begin
                    failures++;
                    $display("FAIL bcast_data beat=%0d out=%0d got=%h exp=%h",
                             i, k, o_data_bus[k*DW +: DW], exp_d);
                end
            end
        end
        i_valid = 1'b0;
        tick();
        checks++;
        if (o_valid !== 4'b0000) begin
            failures++;
            $display("FAIL bcast_idle got=%b exp=0000", o_valid);
        end
    endtask

    task automatic test_multicast_slow();
        i_en       = 1'b1;
        i_ready    = 4'b1011;
        i_valid    = 1'b1;
        i_data_bus = 32'h55;
        i_cmd      = 4'b0101;
        tick();
        i_valid = 1'b0;
        // Cycle 1: both outputs valid, output 0 handshakes now.
        #1;
        checks++;
        if (o_valid !== 4'b0101) begin
            failures++;
            $display("FAIL mc_valid_c1 got=%b exp=0101", o_valid);
        end
        checks++;
        if (o_data_bus[0*DW +: DW] !== 32'h55) begin
            failures++;
            $display("FAIL mc_data0_c1 got=%h exp=55", o_data_bus[0*DW +: DW]);
        end
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL mc_ready_c1 got=%b exp=0", o_ready);
        end
        // Cycles 2 and 3: only output 2 remains, held with its data.
        for (int c = 2; c <= 3; c++) begin
            tick();
            checks++;
            if (o_valid !== 4'b0100) begin
                failures++;
                $display("FAIL mc_valid_c%0d got=%b exp=0100", c, o_valid);
            end
            checks++;
            if (o_data_bus[2*DW +: DW] !== 32'h55) begin
                failures++;
                $display("FAIL mc_data2_c%0d got=%h exp=55", c, o_data_bus[2*DW +: DW]);
            end
            checks++;
            if (o_data_bus[0*DW +: DW] !== 32'h0) begin
                failures++;
                $display("FAIL mc_dummy0_c%0d got=%h exp=0", c, o_data_bus[0*DW +: DW]);
            end
            if (c == 2) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL mc_ready_c2 got=%b exp=0", o_ready);
                end
            end
        end
        // Cycle 3: output 2 becomes ready and the next beat enters the same cycle.
        i_ready    = 4'b1111;
        i_valid    = 1'b1;
        i_data_bus = 32'h66;
        i_cmd      = 4'b0010;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL mc_ready_release got=%b exp=1", o_ready);
        end
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 4'b0010) begin
            failures++;
            $display("FAIL mc_next_valid got=%b exp=0010", o_valid);
        end
        checks++;
        if (o_data_bus[1*DW +: DW] !== 32'h66) begin
            failures++;
            $display("FAIL mc_next_data got=%h exp=66", o_data_bus[1*DW +: DW]);
        end
        tick();
    endtask

    task automatic test_drop_saturation();
        logic [CW-1:0] exp_cnt;
        i_en    = 1'b1;
        i_ready = 4'b1111;
        i_cmd   = 4'b0000;
        i_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            i_data_bus = 32'(i);
            tick();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++;
            if (o_drop_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL drop_cnt beat=%0d got=%0d exp=%0d", i, o_drop_cnt, exp_cnt);
            end
            checks++;
            if (o_valid !== 4'b0000) begin
                failures++;
                $display("FAIL drop_valid beat=%0d got=%b exp=0000", i, o_valid);
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_en_gating();
        i_en       = 1'b1;
        i_ready    = 4'b0000;
        i_valid    = 1'b1;
        i_data_bus = 32'h33;
        i_cmd      = 4'b0010;
        tick();
        i_en       = 1'b0;
        i_ready    = 4'b0010;
        i_data_bus = 32'h44;
        i_cmd      = 4'b0001;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL en_ready_low got=%b exp=0", o_ready);
        end
        checks++;
        if (o_valid !== 4'b0010 || o_data_bus[1*DW +: DW] !== 32'h33) begin
            failures++;
            $display("FAIL en_drain got=%b/%h exp=0010/33", o_valid, o_data_bus[1*DW +: DW]);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (o_valid !== 4'b0000) begin
                failures++;
                $display("FAIL en_no_accept cyc=%0d got=%b exp=0000", c, o_valid);
            end
        end
        i_en = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL en_ready_high got=%b exp=1", o_ready);
        end
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 4'b0001 || o_data_bus[0*DW +: DW] !== 32'h44) begin
            failures++;
            $display("FAIL en_accept got=%b/%h exp=0001/44", o_valid, o_data_bus[0*DW +: DW]);
        end
        i_ready = 4'b1111;
        tick();
    endtask

    task automatic test_reset_mid();
        i_en       = 1'b1;
        i_ready    = 4'b0000;
        i_valid    = 1'b1;
        i_data_bus = 32'h77;
        i_cmd      = 4'b1000;
        tick();
        i_valid = 1'b0;
        checks++;
        if (o_valid !== 4'b1000) begin
            failures++;
            $display("FAIL rm_pending got=%b exp=1000", o_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 4'b0000 || o_data_bus !== '0) begin
            failures++;
            $display("FAIL rm_async_clear got=%b/%h exp=0000/0", o_valid, o_data_bus);
        end
        checks++;
        if (o_drop_cnt !== 4'd0) begin
            failures++;
            $display("FAIL rm_drop_clear got=%0d exp=0", o_drop_cnt);
        end
        @(posedge clk);
        #2;
        rst_n   = 1'b1;
        i_ready = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_valid !== 4'b0000 || o_data_bus[3*DW +: DW] === 32'h77) begin
                failures++;
                $display("FAIL rm_no_replay cyc=%0d got=%b/%h exp=0000/0",
                         c, o_valid, o_data_bus[3*DW +: DW]);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        i_en       = 1'b0;
        i_valid    = 1'b0;
        i_data_bus = '0;
        i_cmd      = '0;
        i_ready    = '0;
        test_reset();
        test_broadcast();
        test_multicast_slow();
        test_drop_saturation();
        test_en_gating();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_distribute_switch_fork
`default_nettype wire

// File: doc/distribute_switch_fork.md
# distribute_switch_fork

Registered, parametrised 1-to-NUM_OUT distribute switch with per-output valid/ready flow control. One input beat is delivered to any subset of outputs (unicast, multicast, broadcast) chosen by a per-beat destination mask. A single holding stage tracks which destinations still owe an acceptance, so slow consumers stall only the input, never each other. Sits at each fan-out node of the distribution tree, replacing the combinational two-way switch where backpressure and pipelining are needed.

## Interface
- DATA_WIDTH, 32, payload width per beat
- NUM_OUT, 4, number of output ports (>= 2)
- CNT_WIDTH, 16, width of the dropped-beat status counter
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_en  input  1  switch enable; gates input acceptance only
- i_valid  input  1  input beat valid
- o_ready  output  1  switch can accept the input beat this cycle
- i_data_bus  input  DATA_WIDTH  input payload
- i_cmd  input  NUM_OUT  destination mask; bit k = deliver to output k
- o_valid  output  NUM_OUT  per-output valid
- i_ready  input  NUM_OUT  per-output downstream ready
- o_data_bus  output  NUM_OUT*DATA_WIDTH  output k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_drop_cnt  output  CNT_WIDTH  beats accepted with i_cmd == 0

## Operation
- State: data_q (DATA_WIDTH), pend_q (NUM_OUT), drop_q (CNT_WIDTH).
- o_valid = pend_q. o_data_bus slice k = data_q if pend_q[k], else all zeros (dummy data).
- Output k handshake completes when o_valid[k] && i_ready[k]; that bit clears next edge.
- drain_done = ((pend_q & ~i_ready) == 0), i.e. nothing pending or every pending output handshakes this cycle.
- o_ready = i_en && drain_done. Combinational from pend_q, i_ready, i_en; never from i_valid.
- accept = i_valid && o_ready.
- Next state: pend_q <= accept ? i_cmd : (pend_q & ~i_ready); data_q <= i_data_bus on accept, else hold.
- i_cmd == 0 on accept: beat consumed, no output asserted, drop_q increments, saturating at all-ones.
- i_cmd captured only on accept; changes while not accepted are ignored.
- i_en low: no acceptance; already-pending outputs keep presenting and draining normally.
- Outputs may complete in any order and any cycle; the beat retires when the last pending bit clears.
- i_ready[k] with pend_q[k] == 0 has no effect.
- o_valid[k] never drops before its handshake; data on a valid output stays stable until accepted.

## Timing
- Latency: accept at edge N, o_valid visible after edge N (next cycle).
- Throughput: one beat/cycle while all addressed outputs are ready.
- Back-to-back: the same-cycle drain and accept of a new beat is legal; the new mask overwrites pend_q with no bubble.
- Reset (rst_n low, asynchronous): pend_q=0, data_q=0, drop_q=0, so o_valid=0, o_data_bus=0, o_drop_cnt=0. o_ready = i_en (pend is empty).
- Reset mid-transfer: pending beat discarded and never re-presented. First possible accept is the first edge after rst_n deasserts.

## Structure
- Shared package distribute_pkg: DUMMY_DATA constant (zeros) and the mask-helper constants CMD_NONE (all zeros) and CMD_BCAST (all ones), shared with the other distribution-tree switches.
- Single flat module with a generate loop for per-output data gating.
- No sub-module is needed. The saturating counter stays inline.

## Test plan
- Reset: hold rst_n low, drive i_valid=1, i_cmd=4'b1111 -> o_valid=0, o_data_bus=0, o_drop_cnt=0. After release with i_en=1, o_ready=1.
- Broadcast, all ready: beats 0xA0..0xA7, i_cmd=4'b1111, i_ready=4'b1111 -> 8 beats on every output in order, o_ready held 1, one beat per cycle.
- Multicast with a slow consumer: 0x55, i_cmd=4'b0101, i_ready[2]=0 for 3 cycles -> output 0 done at cycle 1, o_valid[2] with 0x55 held 3 cycles, o_ready=0 until i_ready[2] rises. Next beat accepted in that same cycle.
- Drop and saturation: CNT_WIDTH=4, send 17 beats with i_cmd=0 -> no o_valid, o_drop_cnt stops at 15.
- i_en gating: beat 0x33 to output 1 pending, i_en=0, i_ready[1]=1 -> 0x33 delivered, o_ready=0, and a second input beat is not accepted until i_en=1.
- Reset mid-transfer: 0x77 pending on output 3 with i_ready=0, pulse rst_n low -> o_valid clears immediately (asynchronously), and 0x77 never appears afterwards.
